timer_irq_unit: RTL and testbench
=================================

Name: timer_irq_unit

Overview:
- Memory-mapped timer and interrupt-flag block; the upstream source of the CPU's IF and IE inputs.
- Owns DIV/TIMA/TMA/TAC (0xFF04-0xFF07), IF (0xFF0F) and IE (0xFFFF).
- Latches interrupt requests from the timer and the external peripherals.
- Presents a registered read port that the MMU muxes onto the CPU read bus. The CPU clears serviced IF bits through the write port.

Parameters:
OVF_DELAY, 4, clocks TIMA reads 0x00 after overflow before the TMA reload and the IF[2] set
DIV_WIDTH, 16, width of the internal free-running divider; DIV register = top 8 bits

Ports:
clk  in  1  system clock, one T-cycle per edge
rst  in  1  asynchronous, active-high reset
addr  in  16  bus address from MMU
write_enable  in  1  write strobe, sampled each clk
write_value  in  8  write data
read_out  out  8  registered read data for addr of previous clk
hit  out  1  registered; 1 if previous-clk addr mapped to this block
irq_req  in  5  one-cycle pulses: [0] vblank, [1] stat, [3] serial, [4] joypad; [2] ignored
reg_IF  out  8  IF register, feeds CPU mmio_reg_IF
reg_IE  out  8  IE register, feeds CPU mmio_reg_IE

Behaviour:
- Reset (async): div=0, TIMA=0, TMA=0, TAC=0, IF=0xE0, IE=0x00, read_out=0, hit=0, state=COUNT, edge register=0.
- Divider: increments every clk and wraps at 2^DIV_WIDTH. Any write to 0xFF04 clears the whole divider, data ignored.
- Tick source:
  - sel = div bit TAC[1:0]: 00 -> bit9, 01 -> bit3, 10 -> bit5, 11 -> bit7.
  - t = sel & TAC[2].
  - TIMA increments on a 1->0 transition of t (registered edge detector). Disabling TAC[2] while sel=1 therefore produces one tick.
- Timer FSM:
  - COUNT: on a tick with TIMA=0xFF, TIMA becomes 0x00 and the FSM enters DELAY with cnt=OVF_DELAY-1.
  - DELAY: cnt decrements each clk. At cnt=0 -> RELOAD.
  - A CPU write to TIMA in DELAY loads the written value, cancels the reload, and returns the FSM to COUNT. No IF set.
  - Ticks during DELAY are ignored.
  - RELOAD (one clk): TIMA<=TMA and IF[2]<=1. A TMA write in the same clk is forwarded, so TIMA gets the new value. CPU writes to TIMA in this clk are dropped. Next state COUNT.
- TIMA write in COUNT in the same clk as a tick: the write wins, no increment.
- TAC: only bits [2:0] are stored; reads return {5'b11111, TAC[2:0]}.
- IF:
  - Write stores write_value[4:0], then ORs in same-cycle hardware sets, so a set wins over a clear.
  - Bits [7:5] always read 1.
  - irq_req[i] pulses OR into IF[i]; IF[2] is set only by the timer.
- IE: full 8-bit read/write.
- Read path: read_out/hit update every clk from the current addr, giving 1-clk latency. The read returns the register value before any same-cycle write. Unmapped addresses give read_out=0x00 and hit=0.
- reg_IF/reg_IE are direct register outputs, updated on the clk following the write or set.
- Reset mid-overflow returns to COUNT with TIMA=0 and no IF set.

Optional Feature:
TIMER_DIV_GLITCH_EN
- Defined: writing DIV while t=1 forces t to 0 next clk, producing one TIMA increment (hardware-accurate glitch).
- Undefined: a DIV write also clears the edge register, so no increment ever results from a DIV write.

Test Plan:
- DIV: after reset, run 256 clks -> DIV reads 0x01. Write 0xAB to 0xFF04 -> next read 0x00.
- Overflow and reload: TMA=0x80, TIMA=0xFE, TAC=0x05 (bit3, 16 clks/tick).
  - Within 32 clks, TIMA overflows and reads 0x00 for 4 clks.
  - Then TIMA=0x80 and reg_IF=0xE4.
- Reload cancel: same setup, write TIMA=0x33 two clks after overflow -> TIMA=0x33 and IF[2] stays 0.
- IF race: irq_req[0] pulse in the same clk as a write of 0x00 to 0xFF0F -> reg_IF=0xE1 next clk. Write 0x1F -> IF reads 0xFF.
- Tick rates: for each TAC in 0x04..0x07, count TIMA increments over 4096 clks -> 4, 256, 64, 16. TAC=0x03 -> 0.
- DIV glitch: TAC=0x05, write DIV when div bit3=1 -> TIMA +1 with TIMER_DIV_GLITCH_EN defined, +0 without.

Source files
------------

// File: rtl/timer_irq_unit.sv
// Memory-mapped DIV/TIMA/TMA/TAC timer with IF/IE interrupt flag registers and a 1-clk registered read port.
// Optional build macro: TIMER_DIV_GLITCH_EN (a DIV write while the tick source is high yields one TIMA increment).
module timer_irq_unit #(
  parameter int OVF_DELAY = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        write_enable,
  input  logic [7:0]  write_value,
  output logic [7:0]  read_out,
  output logic        hit,
  input  logic [4:0]  irq_req,
  output logic [7:0]  reg_IF,
  output logic [7:0]  reg_IE
);
  localparam int CW = (OVF_DELAY < 2) ? 1 : $clog2(OVF_DELAY + 1);

  localparam logic [1:0] S_COUNT  = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_RELOAD = 2'd2;

  logic [DIV_WIDTH-1:0] div;
  logic [7:0]           tima, tma, ie;
  logic [2:0]           tac;
  logic [4:0]           if_r;
  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic                 t_q, sel, t, tick, timer_set;
  logic [4:0]           sets;
  logic [7:0]           rdata;
  logic                 rhit;
  logic                 unused_irq2;

  wire wr_div  = write_enable && (addr == 16'hFF04);
  wire wr_tima = write_enable && (addr == 16'hFF05);
  wire wr_tma  = write_enable && (addr == 16'hFF06);
  wire wr_tac  = write_enable && (addr == 16'hFF07);
  wire wr_if   = write_enable && (addr == 16'hFF0F);
  wire wr_ie   = write_enable && (addr == 16'hFFFF);

  assign unused_irq2 = irq_req[2];

  always_comb begin
    sel = div[9];
    case (tac[1:0])
      2'b01:   sel = div[3];
      2'b10:   sel = div[5];
      2'b11:   sel = div[7];
      default: sel = div[9];
    endcase
  end

  assign t         = sel & tac[2];
  assign tick      = t_q & ~t;
  assign timer_set = (state == S_RELOAD);
  assign sets      = {irq_req[4:3], timer_set, irq_req[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      t_q <= 1'b0;
    end else begin
      div <= wr_div ? '0 : div + 1'b1;
`ifdef TIMER_DIV_GLITCH_EN
      t_q <= t;
`else
      // Clearing the edge register hides the falling edge a DIV reset would cause.
      t_q <= wr_div ? 1'b0 : t;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tima  <= 8'h00;
      state <= S_COUNT;
      cnt   <= '0;
    end else begin
      case (state)
        S_COUNT: begin
          if (wr_tima) tima <= write_value;
          else if (tick) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              state <= S_DELAY;
              cnt   <= CW'(OVF_DELAY - 1);
            end else begin
              tima <= tima + 8'h01;
            end
          end
        end
        S_DELAY: begin
          if (wr_tima) begin
            tima  <= write_value;
            state <= S_COUNT;
          end else begin
            cnt <= cnt - 1'b1;
            // Leave as cnt reaches 0 so TIMA reads 0x00 for OVF_DELAY clocks in total.
            if (cnt <= CW'(1)) state <= S_RELOAD;
          end
        end
        S_RELOAD: begin
          tima  <= wr_tma ? write_value : tma;
          state <= S_COUNT;
        end
        default: state <= S_COUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tma  <= 8'h00;
      tac  <= 3'b000;
      ie   <= 8'h00;
      if_r <= 5'h00;
    end else begin
      if (wr_tma) tma <= write_value;
      if (wr_tac) tac <= write_value[2:0];
      if (wr_ie)  ie  <= write_value;
      // Hardware sets are ORed after the CPU write so a set beats a clear.
      if (wr_if) if_r <= write_value[4:0] | sets;
      else       if_r <= if_r | sets;
    end
  end

  always_comb begin
    rdata = 8'h00;
    rhit  = 1'b1;
    case (addr)
      16'hFF04: rdata = div[DIV_WIDTH-1 -: 8];
      16'hFF05: rdata = tima;
      16'hFF06: rdata = tma;
      16'hFF07: rdata = {5'b11111, tac};
      16'hFF0F: rdata = {3'b111, if_r};
      16'hFFFF: rdata = ie;
      default:  rhit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_out <= 8'h00;
      hit      <= 1'b0;
    end else begin
      read_out <= rdata;
      hit      <= rhit;
    end
  end

  assign reg_IF = {3'b111, if_r};
  assign reg_IE = ie;
endmodule

// File: tb/tb_timer_irq_unit.sv
// Directed bench for timer_irq_unit: DIV, overflow/reload, reload cancel, IF races, tick rates, DIV glitch.
module tb_timer_irq_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        write_enable = 1'b0;
  logic [7:0]  write_value = 8'h00;
  logic [7:0]  read_out;
  logic        hit;
  logic [4:0]  irq_req = 5'h00;
  logic [7:0]  reg_IF, reg_IE;

  int checks = 0;
  int errors = 0;

  timer_irq_unit dut (
    .clk(clk), .rst(rst), .addr(addr), .write_enable(write_enable),
    .write_value(write_value), .read_out(read_out), .hit(hit),
    .irq_req(irq_req), .reg_IF(reg_IF), .reg_IE(reg_IE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; write_enable = 1'b1; write_value = d;
    @(posedge clk); #1;
    write_enable = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr = a;
    @(posedge clk); #1;
    d = read_out;
    addr = 16'h0000;
  endtask

  // Poll TIMA until it reads v; the flag reports whether it showed up within the budget.
  task automatic wait_tima(input logic [7:0] v, input int budget, output bit found);
    found = 1'b0;
    addr = 16'hFF05;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (read_out == v) found = 1'b1;
    end
  endtask

  logic [7:0] d, prev;
  bit found;
  int zeros, changes;
  logic [7:0] tac_v [5] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h03};
  int         exp_n [5] = '{4, 256, 64, 16, 0};

  initial begin
    #2;
    chk("rst_if", reg_IF, 8'hE0);
    chk("rst_ie", reg_IE, 8'h00);
    chk("rst_rd", read_out, 8'h00);
    chk("rst_hit", hit, 1'b0);
    @(negedge clk); rst = 1'b0;

    // DIV
    repeat (256) @(posedge clk);
    rd(16'hFF04, d); chk("div_256", d, 8'h01);
    chk("div_hit", hit, 1'b1);
    wr(16'hFF04, 8'hAB);
    rd(16'hFF04, d); chk("div_clear", d, 8'h00);
    rd(16'hC000, d); chk("unmapped_rd", d, 8'h00);
    chk("unmapped_hit", hit, 1'b0);

    // IE / TAC storage
    wr(16'hFFFF, 8'h5A); chk("ie_port", reg_IE, 8'h5A);
    rd(16'hFFFF, d); chk("ie_rd", d, 8'h5A);
    wr(16'hFF07, 8'hF9);
    rd(16'hFF07, d); chk("tac_rd", d, 8'hF9);
    wr(16'hFF07, 8'h00);

    // Overflow and reload
    wr(16'hFF06, 8'h80);
    wr(16'hFF05, 8'hFE);
    wr(16'hFF04, 8'h00);
    wr(16'hFF07, 8'h05);
    wait_tima(8'h00, 40, found); chk("ovf_seen", found, 1'b1);
    zeros = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (read_out != 8'h00) break;
      zeros++;
    end
    chk("ovf_zero_clks", zeros[15:0], 16'd4);
    chk("reload_val", read_out, 8'h80);
    chk("reload_if", reg_IF, 8'hE4);
    wr(16'hFF0F, 8'h00); chk("if_clear", reg_IF, 8'hE0);

    // Reload cancel: write TIMA two clks after overflow
    wr(16'hFF05, 8'hFE);
    wait_tima(8'h00, 40, found); chk("cancel_ovf_seen", found, 1'b1);
    wr(16'hFF05, 8'h33);
    rd(16'hFF05, d); chk("cancel_tima", d, 8'h33);
    tick(6);
    chk("cancel_no_if", reg_IF, 8'hE0);
    rd(16'hFF05, d); chk("cancel_tima_hold", d, 8'h33);
    wr(16'hFF07, 8'h00);

    // IF races
    addr = 16'hFF0F; write_enable = 1'b1; write_value = 8'h00; irq_req = 5'h01;
    @(posedge clk); #1;
    write_enable = 1'b0; irq_req = 5'h00;
    chk("if_set_beats_clr", reg_IF, 8'hE1);
    wr(16'hFF0F, 8'h1F);
    rd(16'hFF0F, d); chk("if_all", d, 8'hFF);
    wr(16'hFF0F, 8'h00);
    irq_req = 5'h04; tick(1); irq_req = 5'h00;
    chk("if_bit2_ignored", reg_IF, 8'hE0);
    irq_req = 5'h18; tick(1); irq_req = 5'h00;
    chk("if_ser_joy", reg_IF, 8'hF8);
    wr(16'hFF0F, 8'h00);

    // Tick rates over 4096 clks
    wr(16'hFF06, 8'h00);
    for (int k = 0; k < 5; k++) begin
      wr(16'hFF07, 8'h00);
      wr(16'hFF05, 8'h00);
      tick(8);
      wr(16'hFF04, 8'h00);
      wr(16'hFF07, tac_v[k]);
      addr = 16'hFF05; prev = 8'h00; changes = 0;
      for (int i = 0; i < 4110; i++) begin
        @(posedge clk); #1;
        if (read_out != prev) changes++;
        prev = read_out;
      end
      chk($sformatf("rate_tac%0h", tac_v[k]), changes[15:0], exp_n[k][15:0]);
    end
    wr(16'hFF07, 8'h00);
    tick(8);

    // DIV write while the bit3 tick source is high
    wr(16'hFF05, 8'h10);
    wr(16'hFF04, 8'h00);
    wr(16'hFF07, 8'h05);
    tick(8);
    wr(16'hFF04, 8'h00);
    tick(1);
    rd(16'hFF05, d);
`ifdef TIMER_DIV_GLITCH_EN
    chk("div_glitch", d, 8'h11);
`else
    chk("div_glitch", d, 8'h10);
`endif

    // Reset in the middle of an overflow
    wr(16'hFF0F, 8'h00);
    wr(16'hFF05, 8'hFF);
    wait_tima(8'h00, 40, found); chk("rst_ovf_seen", found, 1'b1);
    rst = 1'b1; #2; rst = 1'b0;
    tick(8);
    chk("rst_ovf_if", reg_IF, 8'hE0);
    rd(16'hFF05, d); chk("rst_ovf_tima", d, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
